uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
- Read-side consumer for the 8-bit socetlib byte FIFO.
- Pops bytes through the FIFO's show-ahead read port (REN/rdata/empty) and serializes each one as a UART 8N1 frame, or 8N2 when STOP_BITS=2, on a single tx line.
- Sits between the peripheral's TX FIFO and the pad.
- Frames go out back-to-back while data is available and enable is high.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; must be >= 2.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- enable  input  1  permits popping new bytes; a frame in flight always completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rdata  input  8  FIFO head byte; valid combinationally while fifo_empty=0.
- fifo_ren  output  1  FIFO pop strobe.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse on the last stop-bit cycle.

Behaviour:
- Reset: on a rising CLK edge with RST=1, the block enters IDLE and clears the bit counter and cycle counter.
  - During and after reset: tx=1, busy=0, frame_done=0, fifo_ren=0.
  - RST has priority over all other inputs.
- States: IDLE, START, DATA, STOP.
- Pop condition (pop_ok): enable=1 and fifo_empty=0.
- fifo_ren is combinational:
  - fifo_ren = pop_ok and (state==IDLE, or state==STOP and in the last stop cycle).
  - fifo_ren is never asserted while fifo_empty=1, so the FIFO never sees an underrun.
- On the edge where fifo_ren=1: fifo_rdata is latched into an 8-bit shift register, the cycle counter is cleared, and the state moves to START.
- tx is driven only from flops (no input-to-tx combinational path):
  - START: tx=0.
  - DATA: tx = shift register bit 0 (LSB first).
  - IDLE and STOP: tx=1.
- Each bit lasts exactly CLKS_PER_BIT cycles. The cycle counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at CLKS_PER_BIT-1.
- START: after CLKS_PER_BIT cycles, go to DATA with bit index 0.
- DATA: at the end of each bit, shift right by one and increment the bit index. After bit 7, go to STOP.
- STOP: lasts STOP_BITS*CLKS_PER_BIT cycles. On the last cycle:
  - frame_done=1.
  - If pop_ok: pop the next byte and go to START (zero idle gap between frames).
  - Otherwise: go to IDLE.
- Frame length from the first start-bit cycle: (9+STOP_BITS)*CLKS_PER_BIT cycles.
- busy = (state != IDLE).
- enable deasserted mid-frame: the current frame completes normally and no further pops occur.
- RST mid-frame: tx=1 from the next cycle. The popped byte is discarded and no re-pop happens. The next frame starts from the following FIFO byte.
- fifo_rdata changing while not popping is ignored.

Decomposition:
- Package uart_pkg holds:
  - the typedef enum uart_tx_state_t {IDLE, START, DATA, STOP};
  - the localparam UART_DATA_BITS = 8.
- One sub-module, uart_baud_counter, with parameter CLKS_PER_BIT:
  - inputs: CLK, RST, clr;
  - output: bit_end, a single-cycle pulse when the count reaches CLKS_PER_BIT-1.
- The top level instantiates one uart_baud_counter and holds the FSM, shift register and bit/stop counters.

Test Plan:
- Reset (CLKS_PER_BIT=4): RST=1 for 2 cycles with fifo_empty=0 and enable=1 → tx=1, busy=0, fifo_ren=0 throughout reset.
- Single byte: FIFO holds 0xA5, enable=1 → fifo_ren high for exactly 1 cycle. Then:
  - tx = 0 for 4 cycles;
  - tx = 1,0,1,0,0,1,0,1, 4 cycles each;
  - tx = 1 for 4 cycles, with frame_done on cycle 40;
  - busy high for exactly 40 cycles.
- Back-to-back: FIFO holds 0x00 then 0xFF → two fifo_ren pulses exactly 40 cycles apart. The second start bit immediately follows the first stop bit with no idle cycle. The second frame's data bits are all 1.
- Empty/enable gating:
  - fifo_empty=1, enable=1 for 100 cycles → fifo_ren=0, tx=1.
  - Then load 0x3C with enable=0 → no pop.
  - Raise enable → pop on the same cycle enable is seen.
- Mid-frame control:
  - enable dropped during DATA of the first of two bytes → first frame completes and the second byte stays in the FIFO.
  - RST pulsed during data bit 3 → tx=1 and busy=0 the next cycle; after release the second byte is transmitted.
- STOP_BITS=2, CLKS_PER_BIT=2, byte 0x81 → frame is 22 cycles, with stop high for 4 cycles. frame_done appears on the 22nd cycle only.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_counter
// Description : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the
//               final cycle of each bit period with bit_end.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic bit_end
);

    localparam int                 c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Free-running modulo-CLKS_PER_BIT counter, restarted by clr so a new
    // frame always begins on a fresh bit boundary.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bit_end = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_drain
// Description : Drains a show-ahead byte FIFO and serialises each byte as a
//               UART 8N1/8N2 frame. Frames run back-to-back while data is
//               available and enable is high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic                      fifo_empty,
    input  logic [UART_DATA_BITS-1:0] fifo_rdata,
    output logic                      fifo_ren,
    output logic                      tx,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int                 c_IDX_W     = $clog2(UART_DATA_BITS);
    localparam logic [c_IDX_W-1:0] c_LAST_BIT  = c_IDX_W'(UART_DATA_BITS - 1);
    localparam logic [0:0]         c_LAST_STOP = 1'(STOP_BITS - 1);

    uart_tx_state_t              r_state;
    uart_tx_state_t              w_state_nxt;
    logic [UART_DATA_BITS-1:0]   r_shift;
    logic [UART_DATA_BITS-1:0]   w_shift_nxt;
    logic [c_IDX_W-1:0]          r_bit_idx;
    logic [c_IDX_W-1:0]          w_bit_idx_nxt;
    logic [0:0]                  r_stop_cnt;
    logic [0:0]                  w_stop_cnt_nxt;
    logic                        r_tx;
    logic                        w_tx_nxt;

    logic                        w_bit_end;
    logic                        w_pop_ok;
    logic                        w_last_stop;
    logic                        w_ren;
    logic                        w_baud_clr;

    // Pop is allowed only from IDLE or the final stop cycle; RST masks it so
    // the FIFO is never drained while the block is being reset.
    assign w_pop_ok    = enable && !fifo_empty;
    assign w_last_stop = (r_state == STOP) && w_bit_end && (r_stop_cnt == c_LAST_STOP);
    assign w_ren       = !RST && w_pop_ok && ((r_state == IDLE) || w_last_stop);

    // Holding the timer cleared in IDLE and restarting it on every pop aligns
    // the start bit to the pop edge.
    assign w_baud_clr  = (r_state == IDLE) || w_ren;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (w_baud_clr),
        .bit_end (w_bit_end)
    );

    // State and datapath registers; tx is registered so the pad has no
    // combinational path from any input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // Next-state logic: frame sequencing, LSB-first shifting and stop timing.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_cnt_nxt = r_stop_cnt;
        case (r_state)
            IDLE: begin
                if (w_ren) begin
                    w_state_nxt = START;
                    w_shift_nxt = fifo_rdata;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[UART_DATA_BITS-1:1]};
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_nxt    = STOP;
                        w_stop_cnt_nxt = '0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_last_stop) begin
                    if (w_ren) begin
                        w_state_nxt = START;
                        w_shift_nxt = fifo_rdata;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_bit_end) begin
                    w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, derived from where the FSM is going.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign fifo_ren   = w_ren;
    assign tx         = r_tx;
    assign busy       = (r_state != IDLE);
    assign frame_done = w_last_stop && !RST;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo_drain
// Description : Bench for uart_tx_fifo_drain. Two instances (4 clk/bit 8N1,
//               2 clk/bit 8N2) run against a frame-time model plus literal
//               waveform expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_drain;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst   [2];
    logic       en    [2];
    logic       empty [2];
    logic [7:0] rdata [2];
    logic       ren   [2];
    logic       tx    [2];
    logic       busy  [2];
    logic       done  [2];

    uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .CLK(CLK), .RST(rst[0]), .enable(en[0]), .fifo_empty(empty[0]),
        .fifo_rdata(rdata[0]), .fifo_ren(ren[0]), .tx(tx[0]), .busy(busy[0]),
        .frame_done(done[0])
    );

    uart_tx_fifo_drain #(.CLKS_PER_BIT(2), .STOP_BITS(2)) dut_b (
        .CLK(CLK), .RST(rst[1]), .enable(en[1]), .fifo_empty(empty[1]),
        .fifo_rdata(rdata[1]), .fifo_ren(ren[1]), .tx(tx[1]), .busy(busy[1]),
        .frame_done(done[1])
    );

    int vectors    = 0;
    int miscompares = 0;

    function automatic int cpb(int k);
        return (k == 0) ? 4 : 2;
    endfunction
    function automatic int sbits(int k);
        return (k == 0) ? 1 : 2;
    endfunction
    function automatic int flen(int k);
        return (9 + sbits(k)) * cpb(k);
    endfunction

    // Bench FIFO: ring buffer per instance.
    logic [7:0] fmem [2][256];
    int         fh [2];
    int         ft [2];

    task automatic push(int k, logic [7:0] b);
        fmem[k][ft[k] % 256] = b;
        ft[k]++;
    endtask

    task automatic drive_fifo();
        for (int k = 0; k < 2; k++) begin
            empty[k] = (fh[k] == ft[k]);
            rdata[k] = empty[k] ? 8'($urandom) : fmem[k][fh[k] % 256];
        end
    endtask

    // Frame-time model: mt = cycles since the first start-bit cycle, -1 idle.
    int         mt    [2];
    logic [7:0] mb    [2];
    bit         armed [2];

    function automatic logic m_tx(int k);
        int bp;
        if (mt[k] < 0) return 1'b1;
        bp = mt[k] / cpb(k);
        if (bp == 0) return 1'b0;
        if (bp <= 8) return mb[k][bp-1];
        return 1'b1;
    endfunction
    function automatic logic m_ren(int k);
        return !rst[k] && en[k] && !empty[k] && (mt[k] < 0 || mt[k] == flen(k) - 1);
    endfunction
    function automatic logic m_done(int k);
        return !rst[k] && (mt[k] == flen(k) - 1);
    endfunction

    task automatic chk(string nm, int k, logic act, logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d @%0t: got %b, expected %b", nm, k, $time, act, exp);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Recording windows for literal waveform checks.
    bit           rec_on    [2];
    int           rec_n     [2];
    int           busy_cnt  [2];
    int           done_cnt  [2];
    int           done_at   [2];
    int           ren_cnt   [2];
    int           ren_first [2];
    int           ren_second[2];
    logic [255:0] rtx       [2];

    task automatic rec_start(int k);
        rec_on[k]     = 1'b1;
        rec_n[k]      = 0;
        busy_cnt[k]   = 0;
        done_cnt[k]   = 0;
        done_at[k]    = -1;
        ren_cnt[k]    = 0;
        ren_first[k]  = -1;
        ren_second[k] = -1;
        rtx[k]        = '0;
    endtask

    task automatic chk_pat(string nm, int k, int s, int n, logic [63:0] exp);
        logic [63:0] got = '0;
        for (int i = 0; i < n; i++) got[n-1-i] = rtx[k][s+i];
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h, expected %h", nm, k, got, exp);
        end
    endtask

    // Compare process: every armed cycle, all outputs against the model.
    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (armed[k]) begin
                chk("tx", k, tx[k], m_tx(k));
                chk("busy", k, busy[k], mt[k] >= 0);
                chk("frame_done", k, done[k], m_done(k));
                chk("fifo_ren", k, ren[k], m_ren(k));
            end
            if (rec_on[k]) begin
                if (rec_n[k] < 256) rtx[k][rec_n[k]] = tx[k];
                if (busy[k]) busy_cnt[k]++;
                if (done[k]) begin done_cnt[k]++; done_at[k] = rec_n[k]; end
                if (ren[k]) begin
                    ren_cnt[k]++;
                    if (ren_cnt[k] == 1) ren_first[k] = rec_n[k];
                    else if (ren_cnt[k] == 2) ren_second[k] = rec_n[k];
                end
                rec_n[k]++;
            end
        end
    end

    // One clock: the model advances on the same edge as the DUT, using the
    // inputs that were stable across that edge.
    task automatic tick();
        bit pop [2];
        for (int k = 0; k < 2; k++) pop[k] = armed[k] && m_ren(k);
        @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                mt[k]    = -1;
                armed[k] = 1'b1;
            end else if (armed[k]) begin
                if (pop[k]) begin
                    mb[k] = fmem[k][fh[k] % 256];
                    fh[k]++;
                    mt[k] = 0;
                end else if (mt[k] >= 0) begin
                    mt[k]++;
                    if (mt[k] == flen(k)) mt[k] = -1;
                end
            end
        end
        drive_fifo();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; en[k] = 1'b1; fh[k] = 0; ft[k] = 0;
            mt[k] = -1; mb[k] = '0; armed[k] = 1'b0; rec_on[k] = 1'b0;
        end
        push(0, 8'h11);
        push(1, 8'h11);
        drive_fifo();

        // Reset with data waiting and enable high.
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_tx", k, tx[k], 1'b1);
            chk("rst_busy", k, busy[k], 1'b0);
            chk("rst_ren", k, ren[k], 1'b0);
        end
        tick();
        rst[0] = 1'b0; rst[1] = 1'b0;
        ticks(60);

        // Single byte on each instance.
        push(0, 8'hA5);
        push(1, 8'h81);
        drive_fifo();
        rec_start(0); rec_start(1);
        ticks(50);
        rec_on[0] = 1'b0; rec_on[1] = 1'b0;
        chk_int("a5_ren_pulses", ren_cnt[0], 1);
        chk_int("a5_ren_at", ren_first[0], 0);
        chk_int("a5_busy_cycles", busy_cnt[0], 40);
        chk_int("a5_done_count", done_cnt[0], 1);
        chk_int("a5_done_cycle", done_at[0], 40);
        chk_pat("a5_wave", 0, 1, 40, 64'h0F0F00F0FF);
        chk_int("81_ren_pulses", ren_cnt[1], 1);
        chk_int("81_busy_cycles", busy_cnt[1], 22);
        chk_int("81_done_count", done_cnt[1], 1);
        chk_int("81_done_cycle", done_at[1], 22);
        chk_pat("81_wave", 1, 1, 22, 64'b0011000000000000111111);

        // Back-to-back 0x00 then 0xFF.
        push(0, 8'h00);
        push(0, 8'hFF);
        drive_fifo();
        rec_start(0);
        ticks(90);
        rec_on[0] = 1'b0;
        chk_int("b2b_ren_pulses", ren_cnt[0], 2);
        chk_int("b2b_ren_spacing", ren_second[0] - ren_first[0], 40);
        chk_int("b2b_busy_cycles", busy_cnt[0], 80);
        chk_pat("b2b_wave1", 0, 1, 40, 64'h000000000F);
        chk_pat("b2b_wave2", 0, 41, 40, 64'h0FFFFFFFFF);

        // Empty FIFO with enable high.
        rec_start(0);
        ticks(100);
        rec_on[0] = 1'b0;
        begin
            int lows = 0;
            for (int i = 0; i < 100; i++) if (rtx[0][i] == 1'b0) lows++;
            chk_int("empty_tx_low_cycles", lows, 0);
        end
        chk_int("empty_ren_pulses", ren_cnt[0], 0);

        // Data present but enable low, then raised.
        en[0] = 1'b0;
        push(0, 8'h3C);
        drive_fifo();
        rec_start(0);
        ticks(10);
        rec_on[0] = 1'b0;
        chk_int("disabled_ren_pulses", ren_cnt[0], 0);
        en[0] = 1'b1;
        rec_start(0);
        ticks(50);
        rec_on[0] = 1'b0;
        chk_int("enable_pop_cycle", ren_first[0], 0);
        chk_int("enable_ren_pulses", ren_cnt[0], 1);
        chk_int("model_byte_3c", int'(mb[0]), 8'h3C);

        // enable dropped mid-frame.
        push(0, 8'h5A);
        push(0, 8'hC3);
        drive_fifo();
        rec_start(0);
        ticks(19);
        en[0] = 1'b0;
        ticks(60);
        rec_on[0] = 1'b0;
        chk_int("drop_ren_pulses", ren_cnt[0], 1);
        chk_int("drop_done_count", done_cnt[0], 1);
        chk_int("drop_fifo_depth", ft[0] - fh[0], 1);
        en[0] = 1'b1;
        ticks(50);

        // RST pulsed during data bit 3.
        push(0, 8'h96);
        push(0, 8'h4B);
        drive_fifo();
        ticks(18);
        rst[0] = 1'b1;
        tick();
        chk("midrst_tx", 0, tx[0], 1'b1);
        chk("midrst_busy", 0, busy[0], 1'b0);
        rst[0] = 1'b0;
        rec_start(0);
        ticks(50);
        rec_on[0] = 1'b0;
        chk_int("midrst_repop_cycle", ren_first[0], 0);
        chk_int("midrst_ren_pulses", ren_cnt[0], 1);
        chk_int("midrst_fifo_depth", ft[0] - fh[0], 0);
        chk_pat("midrst_wave_4b", 0, 1, 40, 64'h0FF0F00F0F);

        // Randomised traffic on both instances.
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 7) == 0 && (ft[k] - fh[k]) < 200) push(k, 8'($urandom));
                if ($urandom_range(0, 63) == 0) en[k] = ~en[k];
                rst[k] = ($urandom_range(0, 599) == 0);
            end
            drive_fifo();
            tick();
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
